// File: rtl/video_timing_controller.sv
// Raster timing generator: h/v position counters, IDLE/RUN/STOPPING sequencing and
// registered sync/visible strobes. Define VIDEO_TIMING_POSITION_EN to add x_o/y_o.
module video_timing_controller #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          pix_ce_i,
  input  logic          enable_i,
  output logic          running_o,
  output logic          visible_o,
  output logic          end_of_visible_line_o,
  output logic          end_of_frame_o,
  output logic          hsync_n_o,
`ifdef VIDEO_TIMING_POSITION_EN
  output logic          vsync_n_o,
  output logic [HW-1:0] x_o,
  output logic [VW-1:0] y_o
`else
  output logic          vsync_n_o
`endif
);

  localparam logic [HW-1:0] H_VIS_C  = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_BEG_C = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END_C = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_VIS_C  = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_BEG_C = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END_C = VW'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          last_h, last_v, active;
  logic          run_d, vis_d, eol_d, eof_d, hs_n_d, vs_n_d;

  assign last_h = (h_q == H_LAST_C);
  assign last_v = (v_q == V_LAST_C);
  assign active = (state_q != IDLE);

  // Next state and next raster position for a ce cycle.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    unique case (state_q)
      IDLE: begin
        h_d = '0;
        v_d = '0;
        if (enable_i) state_d = RUN;
      end
      RUN, STOPPING: begin
        h_d = last_h ? '0 : h_q + HW'(1);
        if (last_h) v_d = last_v ? '0 : v_q + VW'(1);
        if (state_q == RUN) begin
          if (!enable_i) state_d = STOPPING;
        end else if (enable_i) begin
          // re-enable resumes the current raster rather than restarting it
          state_d = RUN;
        end else if (last_h && last_v) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobe decode of the current (pre-increment) position; idle values outside a frame.
  always_comb begin
    run_d  = (state_d != IDLE);
    vis_d  = active && (h_q <  H_VIS_C) && (v_q < V_VIS_C);
    eol_d  = active && (h_q == H_VIS_C) && (v_q < V_VIS_C);
    eof_d  = active && (h_q == '0)      && (v_q == V_VIS_C);
    hs_n_d = !(active && (h_q >= HS_BEG_C) && (h_q < HS_END_C));
    vs_n_d = !(active && (v_q >= VS_BEG_C) && (v_q < VS_END_C));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else if (pix_ce_i) begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      running_o             <= 1'b0;
      visible_o             <= 1'b0;
      end_of_visible_line_o <= 1'b0;
      end_of_frame_o        <= 1'b0;
      hsync_n_o             <= 1'b1;
      vsync_n_o             <= 1'b1;
    end else if (pix_ce_i) begin
      running_o             <= run_d;
      visible_o             <= vis_d;
      end_of_visible_line_o <= eol_d;
      end_of_frame_o        <= eof_d;
      hsync_n_o             <= hs_n_d;
      vsync_n_o             <= vs_n_d;
    end
  end

`ifdef VIDEO_TIMING_POSITION_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_o <= '0;
      y_o <= '0;
    end else if (pix_ce_i) begin
      x_o <= active ? h_q : '0;
      y_o <= active ? v_q : '0;
    end
  end
`endif

endmodule
